hazard_fwd_unit: RTL

Parametrised successor to the single-cycle combinational forwarding logic. Computes per-operand forwarding selects one cycle early (in D), registers them into E, and owns the load-use stall and branch flush control. The load-use stall is multi-cycle and counter-driven. Sits beside the 5-stage pipeline datapath and drives the E-stage operand muxes plus the F/D/E stall and flush controls.

---
 rtl/hazard_fwd_unit.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------------------------
// hazard_fwd_unit
//
// Hazard and forwarding control for a 5-stage (F/D/E/M/W) pipeline.
//
// In D, each source operand is compared against the destinations of the instructions in E, M
// and W. The result is the forwarding select that the operand will need once it reaches E. That
// select is registered into Forward_E, so the E-stage operand muxes see a flop output rather than
// a comparator chain.
//
// The unit also owns the pipeline control:
//   - Load-use stall. The consumer is held in D and bubbles are inserted into E for exactly
//     LOAD_LAT cycles. The first bubble is raised combinationally from IDLE. A down-counter in
//     STALL supplies the remaining LOAD_LAT-1 bubbles.
//   - Branch flush. A taken branch/jump resolved in E flushes D and E. It wins over a load-use
//     hazard in the same cycle and aborts a stall in progress.
//
// Parameters:
//   REG_AW    register address width; address 0 is the hardwired zero register
//   NUM_SRC   source operands per instruction (2 or 3)
//   LOAD_LAT  bubbles per load-use hazard (1..7)
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst        synchronous active-high reset
//   Rs_D       D-stage source addresses; operand i at [i*REG_AW +: REG_AW]
//   RsUsed_D   per-operand "source actually read" flag
//   RD_E       E-stage destination;  RegWriteE / MemReadE qualify it
//   RD_M       M-stage destination;  RegWriteM qualifies it
//   RD_W       W-stage destination;  RegWriteW qualifies it
//   PCSrcE     taken branch/jump resolved in E
//   Forward_E  registered selects, 2 bits per operand:
//              00 regfile, 10 ALUResultM, 01 ResultW, 11 ResultW_q
//   StallF     hold PC
//   StallD     hold IF/ID register
//   FlushD     clear IF/ID register
//   FlushE     insert bubble into ID/EX register
//   StallCnt   cycles with StallD=1     (only when HAZ_PERF_CNT_EN is defined, else 0)
//   FlushCnt   cycles with PCSrcE=1     (only when HAZ_PERF_CNT_EN is defined, else 0)
//
// Build option:
//   HAZ_PERF_CNT_EN  define to build the two 32-bit wrapping performance counters. When it is
//                    undefined both counter outputs are tied to 0 and no counter flops exist.
// ---------------------------------------------------------------------------------------------

module hazard_fwd_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [NUM_SRC*REG_AW-1:0] Rs_D,
    input  logic [NUM_SRC-1:0]        RsUsed_D,

    input  logic [REG_AW-1:0]         RD_E,
    input  logic                      RegWriteE,
    input  logic                      MemReadE,
    input  logic [REG_AW-1:0]         RD_M,
    input  logic                      RegWriteM,
    input  logic [REG_AW-1:0]         RD_W,
    input  logic                      RegWriteW,

    input  logic                      PCSrcE,

    output logic [2*NUM_SRC-1:0]      Forward_E,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic [31:0]               StallCnt,
    output logic [31:0]               FlushCnt
);

    // -----------------------------------------------------------------------------------------
    // Forwarding select encodings.
    // The names describe what the operand mux picks in E. A producer that is in E while the
    // consumer is in D will be in M (ALUResultM) when the consumer reaches E, and so on.
    // -----------------------------------------------------------------------------------------
    localparam logic [1:0] FwdRegfile = 2'b00;
    localparam logic [1:0] FwdAluM    = 2'b10;  // producer currently in E
    localparam logic [1:0] FwdResW    = 2'b01;  // producer currently in M
    localparam logic [1:0] FwdResWq   = 2'b11;  // producer currently in W, held one cycle

    // LOAD_LAT is at most 7, so 3 bits hold LOAD_LAT-1.
    localparam int unsigned CntW = 3;

    typedef enum logic [0:0] {
        StIdle,
        StStall
    } state_e;

    // -----------------------------------------------------------------------------------------
    // Per-operand destination matching and next-select priority (E > M > W).
    // -----------------------------------------------------------------------------------------
    logic [NUM_SRC-1:0]   match_e;
    logic [NUM_SRC-1:0]   match_m;
    logic [NUM_SRC-1:0]   match_w;
    logic [2*NUM_SRC-1:0] fwd_d;
    logic [2*NUM_SRC-1:0] fwd_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] rs;

        assign rs = Rs_D[i*REG_AW +: REG_AW];

        // A destination of x0 never matches, so x0 reads always come from the regfile.
        assign match_e[i] = RegWriteE && (RD_E != '0) && (RD_E == rs) && RsUsed_D[i];
        assign match_m[i] = RegWriteM && (RD_M != '0) && (RD_M == rs) && RsUsed_D[i];
        assign match_w[i] = RegWriteW && (RD_W != '0) && (RD_W == rs) && RsUsed_D[i];

        assign fwd_d[2*i +: 2] = match_e[i] ? FwdAluM  :
                                 match_m[i] ? FwdResW  :
                                 match_w[i] ? FwdResWq :
                                              FwdRegfile;
    end

    // Any single operand that needs a load still in E stalls the whole instruction.
    logic load_use;
    assign load_use = MemReadE && (|match_e);

    // -----------------------------------------------------------------------------------------
    // Stall / flush FSM.
    // -----------------------------------------------------------------------------------------
    state_e            state_q;
    state_e            state_d;
    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        StallF  = 1'b0;
        StallD  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;

        if (PCSrcE) begin
            // The instructions in F and D are on the wrong path. Any stall for the one in D is
            // moot, so the FSM drops back to IDLE.
            FlushD  = 1'b1;
            FlushE  = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_use) begin
                        // The first bubble comes straight from IDLE. The counter then holds the
                        // number of bubbles still owed.
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = StStall;
                            cnt_d   = CntW'(LOAD_LAT - 1);
                        end
                    end
                end

                StStall: begin
                    // E only holds bubbles while stalling, so there is no new hazard check here.
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_d == '0) begin
                        state_d = StIdle;
                    end
                end

                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------------------------
    // Forward_E register. A bubble entering E must never forward, so FlushE clears the select.
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q <= '0;
        end else if (FlushE) begin
            fwd_q <= '0;
        end else begin
            fwd_q <= fwd_d;
        end
    end

    assign Forward_E = fwd_q;

    // -----------------------------------------------------------------------------------------
    // Performance counters.
    // -----------------------------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallD) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (PCSrcE) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule
